mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester arbiter that shares one single-port, synchronous-read data memory between the RV32I CPU data port (m0) and a debug/loader port (m1).
- Round-robin arbitration, with an optional bounded burst lock per requester.
- Read data returns with fixed 1-cycle latency.
- Sits between the CPU/loader and the dmem array in the SoC top level and in the CPU verification bench.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width of all ports
MAX_BURST, 4, max consecutive grants to one locked requester while the other is waiting (>=1)

Ports:
clock  input  1  system clock, all state on posedge
reset  input  1  synchronous, active-high reset
m0_req  input  1  m0 requests an access this cycle
m0_we  input  1  1 = write, 0 = read
m0_lock  input  1  m0 asks to keep ownership after this beat
m0_addr  input  ADDR_WIDTH  byte address
m0_wdata  input  DATA_WIDTH  write data
m0_gnt  output  1  access accepted this cycle (transfer = req & gnt)
m0_rvalid  output  1  read data valid for m0
m0_rdata  output  DATA_WIDTH  read data
m1_*  same set as m0_* for requester 1
mem_en  output  1  memory access enable
mem_we  output  1  memory write enable
mem_addr  output  ADDR_WIDTH  memory address
mem_wdata  output  DATA_WIDTH  memory write data
mem_rdata  input  DATA_WIDTH  memory read data, valid one cycle after mem_en & !mem_we

Behaviour:
- State registers:
  - last (id of the most recent grantee)
  - owner_valid/owner (locked owner)
  - burst_cnt (clog2(MAX_BURST)+1 bits)
  - rv0/rv1 (pending read returns)
- Reset: while reset is high, m0_gnt = m1_gnt = 0, mem_en = mem_we = 0 and rvalids = 0 (combinationally forced). On the next edge: last = 1 (m0 wins the first tie), owner_valid = 0, burst_cnt = 0, rv0 = rv1 = 0.
- Grant is combinational in the same cycle as req. At most one gnt is high per cycle. A gnt is never asserted without its req.
- Arbitration:
  - Only one requester asserts req: it is granted.
  - Both request, no valid owner: grant the requester != last.
  - Both request, owner_valid and burst_cnt < MAX_BURST: grant owner.
  - Both request, owner_valid and burst_cnt == MAX_BURST: grant the non-owner (forced rotation).
- Memory side:
  - mem_en = any gnt.
  - mem_we/mem_addr/mem_wdata are muxed from the granted requester.
  - When idle: mem_en = 0, mem_we = 0, addr/wdata = 0.
- On each transfer from requester i, at the edge:
  - last <= i
  - if mi_lock: burst_cnt <= (owner_valid & owner==i) ? burst_cnt+1 : 1, owner <= i, owner_valid <= 1
  - else: owner_valid <= 0, burst_cnt <= 0
- A cycle with no transfer leaves last unchanged and clears owner_valid and burst_cnt; a lock does not survive an idle cycle.
- A forced rotation grants the non-owner. That transfer follows the rules above (owner replaced if it locks, else cleared).
- Read return:
  - rvi <= transfer_i & !mi_we, so mi_rvalid is high exactly one cycle after an accepted read.
  - mi_rdata = mem_rdata when mi_rvalid, else 0.
  - Writes produce no rvalid.
  - Back-to-back reads from alternating requesters give alternating rvalids with no bubbles.
- Writes take effect at the memory on the grant edge. A read granted the following cycle to the same address returns the new data.
- Reset mid-operation: a read accepted in the cycle reset rises produces no rvalid. Lock and burst state are discarded.
- Requesters must hold req/we/addr/wdata stable until gnt. The arbiter does not register requests.

Test Plan:
- Reset release, m0 reads addr 0x10 (mem holds 0xDEADBEEF) -> m0_gnt=1 same cycle; m0_rvalid=1, m0_rdata=0xDEADBEEF next cycle; m1_rvalid stays 0.
- m0 and m1 request continuously, no lock -> grants alternate m0,m1,m0,m1 starting with m0; mem_addr alternates accordingly; every read returns rvalid on the correct port one cycle later.
- m0 requests with lock=1 continuously, m1 requests from cycle 0, MAX_BURST=4 -> m0 granted 4 consecutive cycles, m1 granted on the 5th, then m0 granted on the 6th.
- m1 writes 0x00000001 to 0xFFFFFFF0, m0 reads 0xFFFFFFF0 the next cycle -> mem_we=1 on the first cycle, m0_rdata=0x00000001 on the cycle after the read grant.
- Lock chain interrupted by a cycle with both req=0 -> owner cleared; next contention is won by the non-last requester, not the former owner.
- Reset asserted in the cycle m1 read is granted -> gnt forced 0 that cycle, no m1_rvalid afterwards; first post-reset tie goes to m0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port, synchronous-read data memory between
// two requesters (m0 = CPU data port, m1 = debug/loader port).
//   - Combinational grant in the request cycle, round-robin on ties.
//   - A requester holding mX_lock keeps ownership for up to MAX_BURST grants
//     while the other side waits; after that the other side is forced in.
//   - Read data returns one cycle after the grant on the granting port.
// Ports:
//   clock, reset            : clock, synchronous active-high reset
//   mX_req/we/lock/addr/wdata : requester X access request (held until gnt)
//   mX_gnt                  : access accepted this cycle
//   mX_rvalid/rdata         : read return, one cycle after an accepted read
//   mem_en/we/addr/wdata    : memory command (zeros when idle)
//   mem_rdata               : memory read data, valid the cycle after a read
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic                  m0_lock,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic                  m1_lock,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int CW = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] MAXB = CW'(MAX_BURST);

  logic          last_q;        // id of the most recent grantee
  logic          owner_q;       // id of the locked owner
  logic          owner_valid_q;
  logic [CW-1:0] burst_cnt_q;   // grants to the current owner, saturates at MAX_BURST
  logic          rv0_q, rv1_q;  // read accepted last cycle

  logic          gnt0, gnt1, pick;
  logic          xfer, xid, xlock;
  logic [CW-1:0] burst_inc;

  // Arbitration. Reset forces all grants low so nothing reaches the memory.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    pick = 1'b0;
    if (!reset) begin
      if (m0_req && !m1_req) begin
        gnt0 = 1'b1;
      end else if (m1_req && !m0_req) begin
        gnt1 = 1'b1;
      end else if (m0_req && m1_req) begin
        if (owner_valid_q)
          pick = (burst_cnt_q < MAXB) ? owner_q : ~owner_q;
        else
          pick = ~last_q;
        gnt0 = ~pick;
        gnt1 = pick;
      end
    end
  end

  assign m0_gnt = gnt0;
  assign m1_gnt = gnt1;

  assign xfer  = gnt0 | gnt1;
  assign xid   = gnt1;
  assign xlock = gnt1 ? m1_lock : m0_lock;

  // Saturating: once at MAX_BURST the owner keeps winning only uncontended
  // cycles, and any contention rotates immediately.
  assign burst_inc = (burst_cnt_q == MAXB) ? burst_cnt_q : burst_cnt_q + CW'(1);

  // Memory command mux; all-zero when idle.
  always_comb begin
    mem_en    = xfer;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt0) begin
      mem_we    = m0_we;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end else if (gnt1) begin
      mem_we    = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_q        <= 1'b1;  // m0 wins the first tie
      owner_q       <= 1'b0;
      owner_valid_q <= 1'b0;
      burst_cnt_q   <= '0;
      rv0_q         <= 1'b0;
      rv1_q         <= 1'b0;
    end else begin
      rv0_q <= gnt0 & ~m0_we;
      rv1_q <= gnt1 & ~m1_we;
      if (xfer) begin
        last_q <= xid;
        if (xlock) begin
          burst_cnt_q   <= (owner_valid_q && owner_q == xid) ? burst_inc : CW'(1);
          owner_q       <= xid;
          owner_valid_q <= 1'b1;
        end else begin
          owner_valid_q <= 1'b0;
          burst_cnt_q   <= '0;
        end
      end else begin
        // A lock does not survive an idle cycle.
        owner_valid_q <= 1'b0;
        burst_cnt_q   <= '0;
      end
    end
  end

  assign m0_rvalid = rv0_q & ~reset;
  assign m1_rvalid = rv1_q & ~reset;
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: 64-word memory beside the DUT, a behavioural
// reference model of the arbitration rules, directed scenarios and a
// randomized run with requests held until granted.
module tb_mem_arbiter;
  localparam int AW = 32, DW = 32, MB = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset = 1'b1;
  logic m0_req = 0, m0_we = 0, m0_lock = 0, m1_req = 0, m1_we = 0, m1_lock = 0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_en, mem_we;
  logic [DW-1:0] m0_rdata, m1_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clock(clock), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Memory attached to the DUT: 64 words decoded from addr[7:2].
  logic [DW-1:0] env_mem [64] = '{default: '0};
  logic          pl_en = 1'b0;
  logic [5:0]    pl_idx = '0;
  logic [DW-1:0] pl_dat = '0;
  always @(posedge clock) begin
    if (pl_en) env_mem[pl_idx] <= pl_dat;
    if (mem_en && mem_we) env_mem[mem_addr[7:2]] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= env_mem[mem_addr[7:2]];
  end

  int total = 0, bad = 0;

  // Reference model state.
  logic [DW-1:0] ref_mem [64];
  int  md_last, md_owner, md_run;
  bit  md_ov, md_pend0, md_pend1;
  logic [DW-1:0] md_pdat0, md_pdat1;
  // Current cycle as decided by the model.
  bit  c_rst, c_we, c_lk;
  int  c_who;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic [133:0] want, got;

  function automatic logic [133:0] sample();
    return {m0_gnt, m1_gnt, mem_en, mem_we, mem_addr, mem_wdata,
            m0_rvalid, m1_rvalid, m0_rdata, m1_rdata};
  endfunction

  // Drive one cycle of inputs and work out what the arbiter must show.
  task automatic apply(input bit rst, input bit r0, w0, l0, input logic [31:0] a0, d0,
                       input bit r1, w1, l1, input logic [31:0] a1, d1);
    bit rv0, rv1;
    @(negedge clock);
    reset = rst;
    m0_req = r0; m0_we = w0; m0_lock = l0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_lock = l1; m1_addr = a1; m1_wdata = d1;
    #1;
    c_rst = rst;
    c_who = -1;
    if (!rst) begin
      if (r0 && r1) begin
        if (md_ov) c_who = (md_run >= MB) ? 1 - md_owner : md_owner;
        else       c_who = 1 - md_last;
      end else if (r0) c_who = 0;
      else if (r1) c_who = 1;
    end
    c_we    = (c_who == 0) ? w0 : (c_who == 1) ? w1 : 1'b0;
    c_lk    = (c_who == 0) ? l0 : (c_who == 1) ? l1 : 1'b0;
    c_addr  = (c_who == 0) ? a0 : (c_who == 1) ? a1 : 32'h0;
    c_wdata = (c_who == 0) ? d0 : (c_who == 1) ? d1 : 32'h0;
    rv0 = !rst && md_pend0;
    rv1 = !rst && md_pend1;
    want = {c_who == 0, c_who == 1, c_who >= 0, c_we, c_addr, c_wdata,
            rv0, rv1, rv0 ? md_pdat0 : 32'h0, rv1 ? md_pdat1 : 32'h0};
  endtask

  // Advance the model across the clock edge.
  task automatic commit();
    @(posedge clock);
    if (c_rst) begin
      md_last = 1; md_owner = 0; md_run = 0; md_ov = 0; md_pend0 = 0; md_pend1 = 0;
    end else begin
      md_pend0 = (c_who == 0) && !c_we;
      md_pend1 = (c_who == 1) && !c_we;
      if (md_pend0) md_pdat0 = ref_mem[c_addr[7:2]];
      if (md_pend1) md_pdat1 = ref_mem[c_addr[7:2]];
      if (c_who >= 0 && c_we) ref_mem[c_addr[7:2]] = c_wdata;
      if (c_who >= 0) begin
        if (c_lk) begin
          md_run = (md_ov && md_owner == c_who) ? md_run + 1 : 1;
          md_owner = c_who; md_ov = 1;
        end else begin
          md_ov = 0; md_run = 0;
        end
        md_last = c_who;
      end else begin
        md_ov = 0; md_run = 0;
      end
    end
  endtask

  task automatic idle_cycle(input bit rst);
    apply(rst, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    idle_cycle(1); commit();
  endtask

  task automatic test_reset();
    pl_en = 1; pl_idx = 6'd4; pl_dat = 32'hDEADBEEF;
    ref_mem[4] = 32'hDEADBEEF;
    for (int i = 0; i < 2; i++) begin
      apply(1, 1, 1, 1, 32'h10, 32'h55, 1, 0, 0, 32'h20, 0);
      got = sample(); total++;
      if (got !== want) begin bad++; $display("FAIL reset_all got=%h exp=%h", got, want); end
      total++;
      if ({m0_gnt, m1_gnt, mem_en, mem_we, m0_rvalid, m1_rvalid} !== 6'b0) begin
        bad++; $display("FAIL reset_forced got=%b exp=000000",
                        {m0_gnt, m1_gnt, mem_en, mem_we, m0_rvalid, m1_rvalid});
      end
      commit();
      pl_en = 0;
    end
  endtask

  task automatic test_read();
    apply(0, 1, 0, 0, 32'h10, 0, 0, 0, 0, 0, 0);
    got = sample(); total++;
    if (got !== want) begin bad++; $display("FAIL read_grant got=%h exp=%h", got, want); end
    total++;
    if (m0_gnt !== 1'b1) begin bad++; $display("FAIL read_gnt got=%b exp=1", m0_gnt); end
    commit();
    idle_cycle(0);
    got = sample(); total++;
    if (got !== want) begin bad++; $display("FAIL read_ret got=%h exp=%h", got, want); end
    total++;
    if ({m0_rvalid, m1_rvalid, m0_rdata} !== {2'b10, 32'hDEADBEEF}) begin
      bad++; $display("FAIL read_data got=%b%b %h exp=10 deadbeef", m0_rvalid, m1_rvalid, m0_rdata);
    end
    commit();
  endtask

  task automatic test_alternate();
    int n0 = 0, n1 = 0;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      if (k < 8) apply(0, 1, 0, 0, 32'h40 + 4 * n0, 0, 1, 0, 0, 32'h80 + 4 * n1, 0);
      else idle_cycle(0);
      got = sample(); total++;
      if (got !== want) begin bad++; $display("FAIL alt_%0d got=%h exp=%h", k, got, want); end
      if (k < 8) begin
        total++;
        if ({m0_gnt, m1_gnt} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
          bad++; $display("FAIL alt_order_%0d got=%b%b", k, m0_gnt, m1_gnt);
        end
      end
      commit();
      if (c_who == 0) n0++;
      if (c_who == 1) n1++;
    end
  endtask

  task automatic test_lock_burst();
    logic [5:0] pat = 6'b101111;  // bit k = m0 wins cycle k
    bit m1_pend = 1;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      apply(0, 1, 0, 1, 32'h30, 0, m1_pend, 0, 0, 32'h34, 0);
      got = sample(); total++;
      if (got !== want) begin bad++; $display("FAIL burst_%0d got=%h exp=%h", k, got, want); end
      total++;
      if (m0_gnt !== pat[k] || m1_gnt !== !pat[k]) begin
        bad++; $display("FAIL burst_order_%0d got=%b%b exp=%b", k, m0_gnt, m1_gnt, pat[k]);
      end
      commit();
    end
  endtask

  task automatic test_raw();
    apply(0, 0, 0, 0, 0, 0, 1, 1, 0, 32'hFFFFFFF0, 32'h1);
    got = sample(); total++;
    if (got !== want) begin bad++; $display("FAIL raw_wr got=%h exp=%h", got, want); end
    total++;
    if ({mem_en, mem_we, mem_addr} !== {2'b11, 32'hFFFFFFF0}) begin
      bad++; $display("FAIL raw_we got=%b%b %h exp=11 fffffff0", mem_en, mem_we, mem_addr);
    end
    commit();
    apply(0, 1, 0, 0, 32'hFFFFFFF0, 0, 0, 0, 0, 0, 0);
    got = sample(); total++;
    if (got !== want) begin bad++; $display("FAIL raw_rd got=%h exp=%h", got, want); end
    commit();
    idle_cycle(0);
    got = sample(); total++;
    if (got !== want) begin bad++; $display("FAIL raw_ret got=%h exp=%h", got, want); end
    total++;
    if (m0_rdata !== 32'h1) begin bad++; $display("FAIL raw_data got=%h exp=00000001", m0_rdata); end
    commit();
  endtask

  task automatic test_lock_idle();
    do_reset();
    apply(0, 1, 0, 1, 32'h8, 0, 0, 0, 0, 0, 0);
    commit();
    idle_cycle(0);
    commit();
    apply(0, 1, 0, 0, 32'h8, 0, 1, 0, 0, 32'hC, 0);
    got = sample(); total++;
    if (got !== want) begin bad++; $display("FAIL lock_idle got=%h exp=%h", got, want); end
    total++;
    if ({m0_gnt, m1_gnt} !== 2'b01) begin
      bad++; $display("FAIL lock_idle_win got=%b%b exp=01", m0_gnt, m1_gnt);
    end
    commit();
  endtask

  task automatic test_reset_mid();
    do_reset();
    apply(0, 1, 0, 1, 32'h4, 0, 0, 0, 0, 0, 0);
    commit();
    apply(1, 0, 0, 0, 0, 0, 1, 0, 0, 32'h10, 0);
    got = sample(); total++;
    if (got !== want) begin bad++; $display("FAIL rstmid got=%h exp=%h", got, want); end
    total++;
    if (m1_gnt !== 1'b0) begin bad++; $display("FAIL rstmid_gnt got=%b exp=0", m1_gnt); end
    commit();
    idle_cycle(0);
    got = sample(); total++;
    if (m1_rvalid !== 1'b0) begin bad++; $display("FAIL rstmid_rv got=%b exp=0", m1_rvalid); end
    commit();
    apply(0, 1, 0, 0, 32'h14, 0, 1, 0, 0, 32'h18, 0);
    got = sample(); total++;
    if (got !== want) begin bad++; $display("FAIL rstmid_tie got=%h exp=%h", got, want); end
    total++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin
      bad++; $display("FAIL rstmid_first got=%b%b exp=10", m0_gnt, m1_gnt);
    end
    commit();
  endtask

  task automatic test_random();
    bit p0 = 0, p1 = 0, w0 = 0, w1 = 0, l0 = 0, l1 = 0, rst;
    logic [31:0] a0 = 0, a1 = 0, d0 = 0, d1 = 0;
    for (int i = 0; i < 400; i++) begin
      if (!p0 && $urandom_range(0, 3) != 0) begin
        p0 = 1; w0 = 1'($urandom_range(0, 1)); l0 = 1'($urandom_range(0, 1));
        a0 = 32'($urandom_range(0, 15)) << 2; d0 = $urandom;
      end
      if (!p1 && $urandom_range(0, 3) != 0) begin
        p1 = 1; w1 = 1'($urandom_range(0, 1)); l1 = 1'($urandom_range(0, 1));
        a1 = 32'($urandom_range(0, 15)) << 2; d1 = $urandom;
      end
      rst = ($urandom_range(0, 49) == 0);
      apply(rst, p0, w0, l0, a0, d0, p1, w1, l1, a1, d1);
      got = sample(); total++;
      if (got !== want) begin bad++; $display("FAIL rand_%0d got=%h exp=%h", i, got, want); end
      commit();
      if (c_who == 0) p0 = 0;
      if (c_who == 1) p1 = 0;
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    md_last = 1; md_owner = 0; md_run = 0; md_ov = 0; md_pend0 = 0; md_pend1 = 0;
    md_pdat0 = '0; md_pdat1 = '0;
    test_reset();
    test_read();
    test_alternate();
    test_lock_burst();
    test_raw();
    test_lock_idle();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
